// File: rtl/rs_euclid_pkg.sv
// Shared constants, state encoding and widths for the RS Euclidean key-equation controller.
package rs_euclid_pkg;

  localparam int unsigned T       = 8;
  localparam int unsigned SYM_W   = 8;
  localparam int unsigned DEG_W   = 6;
  localparam int unsigned TMO_CYC = 256;

  localparam int unsigned N_SYN = 2 * T;
  localparam int unsigned FL    = 2 * T + 1;
  localparam int unsigned IDX_W = $clog2(N_SYN);
  localparam int unsigned K_W   = $clog2(FL);

  localparam logic [SYM_W-1:0] GF_ONE = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    WAIT,
    DRAIN,
    BYPASS,
    DONE
  } ctrl_state_e;

endpackage

// File: rtl/euclid_syn_buf.sv
// 2T-entry syndrome register file: ascending write pointer during LOAD,
// descending read index during FEED, running nonzero flag over the block.
module euclid_syn_buf
  import rs_euclid_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_first,
  input  logic [SYM_W-1:0] wr_data,
  input  logic             rd_load,
  input  logic             rd_dec,
  output logic [IDX_W-1:0] wr_cnt,
  output logic [SYM_W-1:0] rd_data,
  output logic             nz
);

  logic [SYM_W-1:0] mem [N_SYN];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  // The first symbol of a block restarts the pointer and the flag in the same cycle.
  assign wr_idx  = wr_first ? '0 : wr_ptr;
  assign wr_cnt  = wr_ptr;
  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_SYN; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_idx <= '0;
      nz     <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_idx] <= wr_data;
        wr_ptr      <= wr_idx + 1'b1;
        nz          <= (wr_first ? 1'b0 : nz) | (|wr_data);
      end
      if (rd_load)
        rd_idx <= IDX_W'(N_SYN - 1);
      else if (rd_dec)
        rd_idx <= rd_idx - 1'b1;
    end
  end

endmodule

// File: rtl/euclid_array_ctrl.sv
// Sequencer for the systolic Euclidean array: loads 2T syndromes, feeds the initial frame,
// drains Lambda/Omega. Define EUCLID_CTRL_TIMEOUT_EN for the WAIT watchdog and err output.
module euclid_array_ctrl
  import rs_euclid_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [SYM_W-1:0] syn_in,
  input  logic             syn_valid,
  output logic             syn_ready,
  output logic             arr_en,
  output logic             arr_start,
  output logic             arr_stop,
  output logic [DEG_W-1:0] arr_deg_R,
  output logic [DEG_W-1:0] arr_deg_Q,
  output logic [SYM_W-1:0] arr_R,
  output logic [SYM_W-1:0] arr_Q,
  output logic [SYM_W-1:0] arr_L,
  output logic [SYM_W-1:0] arr_U,
  input  logic             res_st,
  input  logic [SYM_W-1:0] res_R,
  input  logic [SYM_W-1:0] res_L,
  input  logic [DEG_W-1:0] res_deg_R,
  output logic [SYM_W-1:0] lam_out,
  output logic [SYM_W-1:0] omg_out,
  output logic             coef_valid,
  output logic             coef_first,
  output logic [DEG_W-1:0] deg_omega,
  output logic             no_err,
  output logic             done,
  output logic             busy
`ifdef EUCLID_CTRL_TIMEOUT_EN
  ,
  output logic             err
`endif
);

  ctrl_state_e      state;
  logic [K_W-1:0]   k;
  logic             accept;
  logic             last_acc;
  logic             all_nz;
  logic             nz;
  logic             k_last;
  logic [IDX_W-1:0] wr_cnt;
  logic [SYM_W-1:0] rd_data;

`ifdef EUCLID_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TMO_CYC + 1);
  logic [WD_W-1:0] wd;
`endif

  assign accept    = syn_valid & syn_ready;
  assign last_acc  = accept && (state == LOAD) && (wr_cnt == IDX_W'(N_SYN - 1));
  assign all_nz    = nz | (|syn_in);
  assign k_last    = (k == K_W'(FL - 1));
  assign arr_L     = '0;
  assign arr_stop  = 1'b0;

  euclid_syn_buf u_syn_buf (
    .clk      (clk),
    .rst_n    (reset),
    .wr_en    (accept),
    .wr_first (state == IDLE),
    .wr_data  (syn_in),
    .rd_load  (last_acc),
    .rd_dec   (state == FEED),
    .wr_cnt   (wr_cnt),
    .rd_data  (rd_data),
    .nz       (nz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      k          <= '0;
      syn_ready  <= 1'b0;
      arr_en     <= 1'b0;
      arr_start  <= 1'b1;
      arr_deg_R  <= '0;
      arr_deg_Q  <= '0;
      arr_R      <= '0;
      arr_Q      <= '0;
      arr_U      <= '0;
      lam_out    <= '0;
      omg_out    <= '0;
      coef_valid <= 1'b0;
      coef_first <= 1'b0;
      deg_omega  <= '0;
      no_err     <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
`ifdef EUCLID_CTRL_TIMEOUT_EN
      err        <= 1'b0;
      wd         <= '0;
`endif
    end else begin
      done       <= 1'b0;
      coef_first <= 1'b0;
      case (state)
        IDLE: begin
          syn_ready <= 1'b1;
          if (accept) begin
            state  <= LOAD;
            busy   <= 1'b1;
            no_err <= 1'b0;
`ifdef EUCLID_CTRL_TIMEOUT_EN
            err    <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (last_acc) begin
            syn_ready <= 1'b0;
            k         <= '0;
            if (all_nz) begin
              state     <= FEED;
              arr_en    <= 1'b1;
              arr_start <= 1'b0;
              arr_R     <= GF_ONE;
              arr_Q     <= '0;
              arr_U     <= '0;
              arr_deg_R <= DEG_W'(N_SYN);
              arr_deg_Q <= DEG_W'(N_SYN - 1);
            end else begin
              state      <= BYPASS;
              coef_valid <= 1'b1;
              coef_first <= 1'b1;
              lam_out    <= '0;
              omg_out    <= '0;
              deg_omega  <= '0;
              no_err     <= 1'b1;
            end
          end
        end
        // Outputs are registered one step ahead: at index k the value for k+1 is loaded.
        FEED: begin
          arr_start <= 1'b1;
          arr_R     <= '0;
          if (k_last) begin
            state     <= WAIT;
            k         <= '0;
            arr_Q     <= '0;
            arr_U     <= '0;
            arr_deg_R <= '0;
            arr_deg_Q <= '0;
          end else begin
            k     <= k + 1'b1;
            arr_Q <= rd_data;
            arr_U <= (k == K_W'(FL - 2)) ? GF_ONE : '0;
          end
        end
        WAIT: begin
          if (!res_st) begin
            state      <= DRAIN;
            k          <= '0;
            coef_valid <= 1'b1;
            coef_first <= 1'b1;
            lam_out    <= res_L;
            omg_out    <= res_R;
            deg_omega  <= res_deg_R;
`ifdef EUCLID_CTRL_TIMEOUT_EN
            wd         <= '0;
          end else if (wd == WD_W'(TMO_CYC - 1)) begin
            state  <= DONE;
            wd     <= '0;
            arr_en <= 1'b0;
            done   <= 1'b1;
            err    <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
`endif
          end
        end
        DRAIN: begin
          if (k_last) begin
            state      <= DONE;
            k          <= '0;
            coef_valid <= 1'b0;
            lam_out    <= '0;
            omg_out    <= '0;
            arr_en     <= 1'b0;
            done       <= 1'b1;
          end else begin
            k       <= k + 1'b1;
            lam_out <= res_L;
            omg_out <= res_R;
          end
        end
        BYPASS: begin
          if (k_last) begin
            state      <= DONE;
            k          <= '0;
            coef_valid <= 1'b0;
            lam_out    <= '0;
            done       <= 1'b1;
          end else begin
            k       <= k + 1'b1;
            lam_out <= (k == K_W'(FL - 2)) ? GF_ONE : '0;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          syn_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_euclid_array_ctrl.sv
// Randomized bench for euclid_array_ctrl with a behavioural array responder and frame model.
module tb_euclid_array_ctrl;
  import rs_euclid_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [SYM_W-1:0] syn_in;
  logic             syn_valid;
  logic             syn_ready;
  logic             arr_en, arr_start, arr_stop;
  logic [DEG_W-1:0] arr_deg_R, arr_deg_Q;
  logic [SYM_W-1:0] arr_R, arr_Q, arr_L, arr_U;
  logic             res_st;
  logic [SYM_W-1:0] res_R, res_L;
  logic [DEG_W-1:0] res_deg_R;
  logic [SYM_W-1:0] lam_out, omg_out;
  logic             coef_valid, coef_first;
  logic [DEG_W-1:0] deg_omega;
  logic             no_err, done, busy;
`ifdef EUCLID_CTRL_TIMEOUT_EN
  logic             err;
`endif

  euclid_array_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .syn_in     (syn_in),
    .syn_valid  (syn_valid),
    .syn_ready  (syn_ready),
    .arr_en     (arr_en),
    .arr_start  (arr_start),
    .arr_stop   (arr_stop),
    .arr_deg_R  (arr_deg_R),
    .arr_deg_Q  (arr_deg_Q),
    .arr_R      (arr_R),
    .arr_Q      (arr_Q),
    .arr_L      (arr_L),
    .arr_U      (arr_U),
    .res_st     (res_st),
    .res_R      (res_R),
    .res_L      (res_L),
    .res_deg_R  (res_deg_R),
    .lam_out    (lam_out),
    .omg_out    (omg_out),
    .coef_valid (coef_valid),
    .coef_first (coef_first),
    .deg_omega  (deg_omega),
    .no_err     (no_err),
    .done       (done),
    .busy       (busy)
`ifdef EUCLID_CTRL_TIMEOUT_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Array responder state: result frame contents are chosen by the bench before each block.
  logic [SYM_W-1:0] rl [FL+3];
  logic [SYM_W-1:0] rr [FL+3];
  logic [DEG_W-1:0] rdeg;
  int               lat;
  bit               arr_hold = 1'b0;
  bit               arr_busy = 1'b0;
  logic [SYM_W-1:0] syn [N_SYN];

  // Result frame is deliberately 3 symbols longer than FL.
  initial begin
    res_st = 1'b1; res_R = '0; res_L = '0; res_deg_R = '0;
    forever begin
      @(negedge clk);
      if (reset && arr_en && !arr_start && !arr_hold) begin
        arr_busy = 1'b1;
        repeat (lat - 1) @(negedge clk);
        for (int j = 0; j < FL + 3; j++) begin
          res_st = 1'b0; res_L = rl[j]; res_R = rr[j]; res_deg_R = rdeg;
          @(negedge clk);
        end
        res_st = 1'b1; res_L = '0; res_R = '0; res_deg_R = '0;
        arr_busy = 1'b0;
      end
    end
  end

  task automatic randomize_resp();
    lat  = $urandom_range(20, 60);
    rdeg = DEG_W'($urandom_range(0, N_SYN));
    for (int j = 0; j < FL + 3; j++) begin
      rl[j] = SYM_W'($urandom);
      rr[j] = SYM_W'($urandom);
    end
  endtask

  // Ends on the first negedge after the last accepted syndrome.
  task automatic send_block(input bit gap);
    int w;
    int span;
    span = 0;
    @(negedge clk);
    for (int i = 0; i < N_SYN; i++) begin
      if (i > 0) begin
        @(negedge clk); span++;
        if (gap) begin
          syn_valid = 1'b0; syn_in = SYM_W'($urandom);
          @(negedge clk); span++;
        end
      end
      syn_valid = 1'b1; syn_in = syn[i];
      w = 0;
      while (!syn_ready && w < 200) begin
        @(negedge clk); w++;
        if (i > 0) span++;
      end
      if (w >= 200) chk("syn_ready_timeout", 1'b0, 1'b1);
    end
    @(negedge clk);
    chk("load_span", span, gap ? 30 : 15);
    // gap blocks keep driving garbage syndromes through FEED
    syn_valid = gap;
    syn_in    = SYM_W'($urandom);
  endtask

  // Starts at the k=0 negedge, ends at the first WAIT negedge.
  task automatic check_feed();
    logic [SYM_W-1:0] e_r, e_q, e_u;
    for (int k = 0; k < FL; k++) begin
      e_r = (k == 0) ? 8'h01 : 8'h00;
      e_q = (k == 0) ? 8'h00 : syn[N_SYN - k];
      e_u = (k == FL - 1) ? 8'h01 : 8'h00;
      chk("feed",
          {arr_en, arr_start, arr_stop, arr_R, arr_Q, arr_L, arr_U, arr_deg_R, arr_deg_Q, syn_ready, busy},
          {1'b1, (k != 0), 1'b0, e_r, e_q, 8'h00, e_u, DEG_W'(N_SYN), DEG_W'(N_SYN - 1), 1'b0, 1'b1});
      @(negedge clk);
    end
    syn_valid = 1'b0;
    chk("wait_inputs", {arr_en, arr_start, arr_R, arr_Q, arr_U}, {1'b1, 1'b1, 24'h0});
  endtask

  task automatic run_block(input bit gap, input bit rst_mid);
    bit zero;
    int w;
    logic [SYM_W-1:0] e_l, e_o;
    logic [DEG_W-1:0] e_d;
    zero = 1'b1;
    for (int i = 0; i < N_SYN; i++) if (syn[i] != '0) zero = 1'b0;
    w = 0;
    while (arr_busy && w < 500) begin @(negedge clk); w++; end
    if (w >= 500) chk("array_idle_timeout", 1'b0, 1'b1);
    send_block(gap);
    chk("no_err", no_err, zero);
`ifdef EUCLID_CTRL_TIMEOUT_EN
    chk("err_clear", err, 1'b0);
`endif
    if (!zero) begin
      check_feed();
      w = 0;
      while (!coef_valid && w < 300) begin @(negedge clk); w++; end
      chk("drain_start", coef_valid, 1'b1);
    end else begin
      syn_valid = 1'b0;
    end
    for (int j = 0; j < FL; j++) begin
      if (rst_mid && j == 5) begin
        reset = 1'b0;
        #1;
        chk("rst_mid_start", arr_start, 1'b1);
        chk("rst_mid_outs",
            {syn_ready, arr_en, arr_stop, arr_deg_R, arr_deg_Q, arr_R, arr_Q, arr_L, arr_U,
             lam_out, omg_out, coef_valid, coef_first, deg_omega, no_err, done, busy}, '0);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      e_l = zero ? ((j == FL - 1) ? 8'h01 : 8'h00) : rl[j];
      e_o = zero ? 8'h00 : rr[j];
      e_d = zero ? '0 : rdeg;
      chk("coef", {coef_valid, coef_first, lam_out, omg_out, deg_omega},
          {1'b1, (j == 0), e_l, e_o, e_d});
      if (zero) chk("bypass_arr_en", arr_en, 1'b0);
      @(negedge clk);
    end
    chk("done", {done, coef_valid, busy}, 3'b101);
    @(negedge clk);
    chk("idle", {done, busy, syn_ready, no_err}, {1'b0, 1'b0, 1'b1, zero});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; syn_valid = 1'b0; syn_in = '0;
    lat = 49; rdeg = '0;
    for (int j = 0; j < FL + 3; j++) begin rl[j] = '0; rr[j] = '0; end
    repeat (3) @(negedge clk);
    chk("reset_start", arr_start, 1'b1);
    chk("reset_outs",
        {syn_ready, arr_en, arr_stop, arr_deg_R, arr_deg_Q, arr_R, arr_Q, arr_L, arr_U,
         lam_out, omg_out, coef_valid, coef_first, deg_omega, no_err, done, busy}, '0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ready", syn_ready, 1'b1);

    // ascending syndromes, fixed 49-cycle array latency, res_L = k
    for (int i = 0; i < N_SYN; i++) syn[i] = SYM_W'(i + 1);
    for (int j = 0; j < FL + 3; j++) begin rl[j] = SYM_W'(j); rr[j] = SYM_W'($urandom); end
    lat = 49; rdeg = DEG_W'(3);
    run_block(1'b0, 1'b0);

    // all-zero block takes the bypass
    for (int i = 0; i < N_SYN; i++) syn[i] = '0;
    run_block(1'b0, 1'b0);

    // gapped syn_valid, garbage during FEED
    for (int i = 0; i < N_SYN; i++) syn[i] = SYM_W'($urandom);
    randomize_resp();
    run_block(1'b1, 1'b0);

    // reset in the middle of DRAIN
    for (int i = 0; i < N_SYN; i++) syn[i] = SYM_W'($urandom);
    syn[0] = 8'h5A;
    randomize_resp();
    run_block(1'b0, 1'b1);

    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < N_SYN; i++) syn[i] = SYM_W'($urandom);
      if (b == 2) begin
        for (int i = 0; i < N_SYN; i++) syn[i] = '0;
        syn[N_SYN - 1] = SYM_W'($urandom_range(1, 255));
      end else if (b == 3) begin
        for (int i = 0; i < N_SYN; i++) syn[i] = '0;
        syn[0] = SYM_W'($urandom_range(1, 255));
      end else if (b == 5) begin
        for (int i = 0; i < N_SYN; i++) syn[i] = '0;
      end
      randomize_resp();
      run_block(b[0], 1'b0);
    end

`ifdef EUCLID_CTRL_TIMEOUT_EN
    begin
      int n;
      int w;
      w = 0;
      while (arr_busy && w < 500) begin @(negedge clk); w++; end
      arr_hold = 1'b1;
      for (int i = 0; i < N_SYN; i++) syn[i] = SYM_W'($urandom);
      syn[3] = 8'h11;
      send_block(1'b0);
      check_feed();
      n = 0;
      while (!done && n < TMO_CYC + 50) begin n++; @(negedge clk); end
      chk("tmo_cycles", n, TMO_CYC);
      chk("tmo_flags", {done, err, coef_valid}, 3'b110);
      @(negedge clk);
      chk("tmo_idle", {done, busy, err, arr_en, syn_ready}, 5'b00101);
      arr_hold = 1'b0;
      for (int i = 0; i < N_SYN; i++) syn[i] = SYM_W'($urandom);
      syn[7] = 8'h22;
      randomize_resp();
      run_block(1'b0, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/euclid_array_ctrl.md
Name: euclid_array_ctrl

Overview:
Sequencer for the systolic Euclidean key-equation array in the RS decoder (2T cascaded euclidean cells).
- Accepts 2T syndromes over a valid/ready handshake and builds the initial polynomial frame: R=x^2T, Q=S(x), L=0, U=1.
- Streams that frame into the first cell, then waits for the result frame marker from the last cell.
- Drains the error-locator (Lambda) and evaluator (Omega) coefficients to the Chien/Forney stage.
- Bypasses the array when every syndrome is zero.

Parameters:
T, 8, correctable symbols; syndrome count = 2T, frame length FL = 2T+1
SYM_W, 8, GF(2^8) symbol width
DEG_W, 6, degree field width; must satisfy 2^DEG_W > 2T
TMO_CYC, 256, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
syn_in  in  SYM_W  syndrome symbol, S_0 first
syn_valid  in  1  syndrome symbol valid
syn_ready  out  1  controller can accept a syndrome
arr_en  out  1  array shift enable (drives start_cnt of every cell)
arr_start  out  1  frame marker; idle 1, 0 on first symbol of frame
arr_stop  out  1  stop input of first cell
arr_deg_R  out  DEG_W  initial deg R
arr_deg_Q  out  DEG_W  initial deg Q
arr_R, arr_Q, arr_L, arr_U  out  SYM_W each  initial polynomial streams, high-order coefficient first
res_st  in  1  frame marker from last cell (active 0)
res_R, res_L  in  SYM_W each  Omega / Lambda streams from last cell
res_deg_R  in  DEG_W  final deg R from last cell
lam_out, omg_out  out  SYM_W each  Lambda / Omega coefficients
coef_valid  out  1  lam_out/omg_out valid
coef_first  out  1  first coefficient of the result frame
deg_omega  out  DEG_W  captured res_deg_R
no_err  out  1  all-zero syndrome block
done  out  1  one-cycle completion pulse
busy  out  1  controller not in IDLE

Behaviour:
Reset values:
- All outputs 0, except arr_start=1.
- State is IDLE and all counters are 0.

FSM states:
- IDLE: syn_ready=1. The first accepted syndrome goes to LOAD with cnt=1.
- LOAD: syn_ready=1. Store one symbol per syn_valid&syn_ready. At cnt=2T-1 with an accepted symbol:
  - If the zero-flag OR of all syndromes is 0, go to BYPASS.
  - Otherwise go to FEED.
- FEED: arr_en=1 for exactly FL cycles. Symbol index k runs 0..FL-1:
  - arr_start=0 only at k=0.
  - arr_R = 1 at k=0, 0 otherwise.
  - arr_Q = 0 at k=0, S_{2T-k} for k=1..2T.
  - arr_L = 0.
  - arr_U = 1 at k=FL-1, 0 otherwise.
  - arr_deg_R=2T and arr_deg_Q=2T-1 are held for the whole frame. arr_stop=0.
- WAIT: arr_en=1, inputs return to 0 and arr_start=1. Wait for res_st=0, then go to DRAIN.
- DRAIN: capture res_deg_R into deg_omega in the first DRAIN cycle.
  - Output res_R->omg_out and res_L->lam_out, registered with 1 cycle latency.
  - coef_valid=1 for FL cycles; coef_first marks the first.
  - After the FL-th output, go to DONE.
- BYPASS:
  - Emit FL coefficients with lam_out = 1 at the last coefficient (Lambda=1), 0 elsewhere. omg_out=0.
  - deg_omega=0, no_err=1. Then go to DONE.
- DONE: done=1 for one cycle, go to IDLE. no_err is held until the next syndrome is accepted.

Rules and boundary conditions:
- syn_ready=0 in FEED/WAIT/DRAIN/BYPASS/DONE; syn_valid there is ignored.
- syn_valid gaps in LOAD stall the count; there is no timeout in LOAD.
- Counter k wraps 0..FL-1 only; a FL-1 comparison ends FEED and DRAIN.
- Result frame longer than FL (res_st stays 0): ignored after FL coefficients.
- Reset mid-operation: immediate return to IDLE. The syndrome buffer is cleared and the partial frame is discarded. The array is flushed by its own reset.

Optional Feature:
Macro EUCLID_CTRL_TIMEOUT_EN.
- Defined:
  - A watchdog counts WAIT cycles. At TMO_CYC without res_st=0, pulse done together with an extra output port err=1, then return to IDLE.
  - err resets to 0 and clears on the next syndrome accept.
- Undefined: no err port and no watchdog; WAIT is unbounded.

Decomposition:
- Package rs_euclid_pkg holds:
  - SYM_W, DEG_W and T.
  - A state enum {IDLE, LOAD, FEED, WAIT, DRAIN, BYPASS, DONE}.
  - Constants GF_ONE=8'h01 and FL.
- Sub-module euclid_syn_buf holds:
  - A 2T x SYM_W register file with a write pointer (LOAD) and a descending read index (FEED).
  - A running nonzero flag.
  - All storage uses the same clk and asynchronous active-low reset.

Test Plan:
1. T=8, syndromes S_i=i+1 -> FEED is 17 cycles with arr_start=0 only at k=0; arr_R=01,00..; arr_Q=00,10,0F..01; arr_U=01 only at k=16; arr_deg_R=16, arr_deg_Q=15.
2. All 16 syndromes 00 -> no arr_en; 17 coef_valid cycles with lam_out=01 at the last coefficient, no_err=1, done after 17 outputs.
3. Array model returns res_st=0 with 49-cycle latency, res_L=k, res_deg_R=3 -> lam_out=0..16 with coef_first at the first, deg_omega=3, done=1 for one cycle.
4. syn_valid toggling every other cycle -> LOAD takes 31 cycles, buffer contents exact; syn_valid during FEED is ignored.
5. reset=0 asserted mid-DRAIN -> all outputs 0, arr_start=1, busy=0 immediately; the next block processes correctly.
6. EUCLID_CTRL_TIMEOUT_EN with res_st held at 1 -> err=1 and done=1 at WAIT cycle 256, return to IDLE.
